// File: rtl/mult32x32_pkg.sv
// Shared types and helpers for the 32x32 multiplier sequencing controller.
// Holds the FSM state enum, step constants and step-to-shift/first-step helpers.
package mult32x32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    localparam int MULT_NUM_STEPS = 8;
    localparam int MULT_STEP_W    = 3;

    // Byte position of a (0..3) plus two bytes when the high half of b is used.
    function automatic logic [2:0] mult_step_shift(input logic [MULT_STEP_W-1:0] s);
        return {1'b0, s[1:0]} + {1'b0, s[2], 1'b0};
    endfunction

    // Lowest step whose a byte is non-zero; 0 when nz is empty.
    function automatic logic [MULT_STEP_W-1:0] mult_first_step(input logic [3:0] nz);
        logic [MULT_STEP_W-1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (nz[i]) r = MULT_STEP_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/mult32x32_seq_ctrl_if.sv
// Host/datapath control bundle for mult32x32_seq_ctrl.
// master: host side (drives start/abort/a); slave: the controller.
interface mult32x32_seq_ctrl_if;
    logic        start;
    logic        abort;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [2:0]  shift_sel;
    logic        upd_prod;
    logic        clr_prod;

    modport master (
        output start, abort, a,
        input  busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod
    );

    modport slave (
        input  start, abort, a,
        output busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod
    );
endinterface

// File: rtl/mult32x32_step_sel.sv
// Next-step search for zero-byte skipping (built only with MULT_SKIP_ZERO_EN).
// Ports: step, nz in; next_step (lowest later step with non-zero a byte), last out.
`ifdef MULT_SKIP_ZERO_EN
module mult32x32_step_sel
    import mult32x32_pkg::*;
(
    input  logic [MULT_STEP_W-1:0] step,
    input  logic [3:0]             nz,
    output logic [MULT_STEP_W-1:0] next_step,
    output logic                   last
);

    // Descending scan so the lowest qualifying step is the one kept.
    always_comb begin
        next_step = '0;
        last      = 1'b1;
        for (int i = MULT_NUM_STEPS - 1; i >= 0; i--) begin
            if (i > int'(step) && nz[2'(i)]) begin
                next_step = MULT_STEP_W'(i);
                last      = 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/mult32x32_seq_ctrl.sv
// Moore sequencer stepping the 32x32 shift-and-add datapath through 8 partial products.
// Ports: clk, reset (sync, active-low), bus (slave modport). Option: MULT_SKIP_ZERO_EN.
module mult32x32_seq_ctrl
    import mult32x32_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    mult32x32_seq_ctrl_if.slave  bus
);

    mult_state_t            state, state_n;
    logic [MULT_STEP_W-1:0] step, step_n;
    logic [MULT_STEP_W-1:0] next_step;
    logic [MULT_STEP_W-1:0] first_step;
    logic                   last;
    logic                   empty;
    logic                   accept;

    assign accept = (state == IDLE) && bus.start;

`ifdef MULT_SKIP_ZERO_EN
    logic [3:0] nz, nz_in;

    assign nz_in = {|bus.a[31:24], |bus.a[23:16], |bus.a[15:8], |bus.a[7:0]};
    assign first_step = mult_first_step(nz_in);
    assign empty = (nz == 4'd0);

    // nz is frozen at acceptance so a changing a cannot disturb the sequence.
    always_ff @(posedge clk) begin
        if (!reset) nz <= '0;
        else if (accept) nz <= nz_in;
    end

    mult32x32_step_sel u_step_sel (
        .step      (step),
        .nz        (nz),
        .next_step (next_step),
        .last      (last)
    );
`else
    logic unused_a;

    assign unused_a   = ^bus.a;
    assign first_step = '0;
    assign empty      = 1'b0;
    assign next_step  = step + 3'd1;
    assign last       = (step == 3'd7);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
        end
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = CLR;
                    step_n  = first_step;
                end
            end
            CLR: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    step_n  = '0;
                end else if (empty) begin
                    state_n = DONE;
                end else begin
                    state_n = ACC;
                end
            end
            ACC: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    step_n  = '0;
                end else if (last) begin
                    state_n = DONE;
                    step_n  = '0;
                end else begin
                    step_n  = next_step;
                end
            end
            DONE: begin
                state_n = IDLE;
                step_n  = '0;
            end
            default: begin
                state_n = IDLE;
                step_n  = '0;
            end
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.clr_prod  = (state == CLR);
    assign bus.upd_prod  = (state == ACC);
    assign bus.a_sel     = (state == ACC) ? step[1:0] : 2'd0;
    assign bus.b_sel     = (state == ACC) ? step[2] : 1'b0;
    assign bus.shift_sel = (state == ACC) ? mult_step_shift(step) : 3'd0;

endmodule

// File: tb/tb_mult32x32_seq_ctrl.sv
// Directed testbench for mult32x32_seq_ctrl with a behavioural datapath model.
// Honours MULT_SKIP_ZERO_EN for expected latencies.
module tb_mult32x32_seq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;

    mult32x32_seq_ctrl_if bus ();

    mult32x32_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MULT_SKIP_ZERO_EN
    localparam int LAT_SMALL = 4;
`else
    localparam int LAT_SMALL = 10;
`endif

    int checks = 0;
    int errors = 0;

    int          done_cyc;
    int          done_cnt;
    int          upd_cnt;
    int          clr_cyc;
    logic [2:0]  shifts[16];
    logic [9:0]  out_log[40];
    logic [63:0] prod;

    function automatic logic [9:0] outv();
        return {bus.busy, bus.done, bus.upd_prod, bus.clr_prod,
                bus.a_sel, bus.b_sel, bus.shift_sel};
    endfunction

    // Starts an operation (start sampled at edge 0) and logs cycles 1..ncyc.
    task automatic run(input logic [31:0] av, input logic [31:0] bv,
                       input int ncyc, input int restart_at,
                       input int abort_at, input int rst_at);
        logic [7:0]  ab;
        logic [15:0] bh;
        logic [63:0] pp;
        done_cyc = -1;
        done_cnt = 0;
        upd_cnt  = 0;
        clr_cyc  = -1;
        for (int i = 0; i < 40; i++) out_log[i] = '0;
        @(negedge clk);
        bus.a     = av;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c < 40) out_log[c] = outv();
            if (bus.clr_prod) begin
                prod    = '0;
                clr_cyc = c;
            end
            if (bus.upd_prod) begin
                ab = av[8*bus.a_sel +: 8];
                bh = bus.b_sel ? bv[31:16] : bv[15:0];
                pp = 64'(ab) * 64'(bh);
                prod = prod + (pp << (8 * bus.shift_sel));
                if (upd_cnt < 16) shifts[upd_cnt] = bus.shift_sel;
                upd_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            bus.start = (c == restart_at);
            bus.abort = (c == abort_at);
            reset     = !(c == rst_at);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.a     = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outv() !== 10'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got %b want 0", i, outv());
            end
        end
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_byte_ff();
        run(32'h0000_00FF, 32'hFFFF_0000, 14, -1, -1, -1);
        checks++;
        if (done_cyc !== LAT_SMALL) begin
            errors++;
            $display("FAIL byte_ff_done_cyc: got %0d want %0d", done_cyc, LAT_SMALL);
        end
        checks++;
        if (prod !== 64'h0000_00FE_FF01_0000) begin
            errors++;
            $display("FAIL byte_ff_product: got %h want 000000feff010000", prod);
        end
`ifdef MULT_SKIP_ZERO_EN
        checks++;
        if (upd_cnt !== 2) begin
            errors++;
            $display("FAIL byte_ff_upd_cnt: got %0d want 2", upd_cnt);
        end
`else
        checks++;
        if (upd_cnt !== 8) begin
            errors++;
            $display("FAIL byte_ff_upd_cnt: got %0d want 8", upd_cnt);
        end
`endif
        checks++;
        if (clr_cyc !== 1) begin
            errors++;
            $display("FAIL byte_ff_clr_cyc: got %0d want 1", clr_cyc);
        end
    endtask

    task automatic test_all_ones();
        logic [2:0] exp_sh[8];
        exp_sh = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd5};
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 14, -1, -1, -1);
        checks++;
        if (upd_cnt !== 8) begin
            errors++;
            $display("FAIL ones_upd_cnt: got %0d want 8", upd_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (shifts[i] !== exp_sh[i]) begin
                errors++;
                $display("FAIL ones_shift[%0d]: got %0d want %0d", i, shifts[i], exp_sh[i]);
            end
        end
        checks++;
        if (prod !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL ones_product: got %h want fffffffe00000001", prod);
        end
        checks++;
        if (done_cyc !== 10 || done_cnt !== 1) begin
            errors++;
            $display("FAIL ones_done: got cyc %0d cnt %0d want 10/1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16, 5, -1, -1);
        checks++;
        if (done_cnt !== 1 || done_cyc !== 10) begin
            errors++;
            $display("FAIL busy_start_done: got cnt %0d cyc %0d want 1/10", done_cnt, done_cyc);
        end
        checks++;
        if (out_log[11] !== 10'd0) begin
            errors++;
            $display("FAIL busy_start_idle: got %b want 0", out_log[11]);
        end
        run(32'h0000_0000, 32'h1234_5678, 14, -1, -1, -1);
`ifdef MULT_SKIP_ZERO_EN
        checks++;
        if (done_cyc !== 2 || upd_cnt !== 0) begin
            errors++;
            $display("FAIL zero_a_seq: got done %0d upd %0d want 2/0", done_cyc, upd_cnt);
        end
`else
        checks++;
        if (done_cyc !== 10 || upd_cnt !== 8) begin
            errors++;
            $display("FAIL zero_a_seq: got done %0d upd %0d want 10/8", done_cyc, upd_cnt);
        end
`endif
        checks++;
        if (prod !== 64'd0) begin
            errors++;
            $display("FAIL zero_a_product: got %h want 0", prod);
        end
    endtask

    task automatic test_abort();
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 14, -1, 5, -1);
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d want 0", done_cnt);
        end
        checks++;
        if (out_log[6] !== 10'd0) begin
            errors++;
            $display("FAIL abort_idle: got %b want 0", out_log[6]);
        end
        run(32'h0000_0003, 32'h0000_0005, 14, -1, -1, -1);
        checks++;
        if (done_cyc !== LAT_SMALL || prod !== 64'd15) begin
            errors++;
            $display("FAIL abort_followup: got cyc %0d prod %h want %0d/f",
                     done_cyc, prod, LAT_SMALL);
        end
    endtask

    task automatic test_reset_mid();
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 14, -1, -1, 8);
        checks++;
        if (out_log[8] !== 10'b1010101100) begin
            errors++;
            $display("FAIL rst_mid_step6: got %b want 1010101100", out_log[8]);
        end
        checks++;
        if (out_log[9] !== 10'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b want 0", out_log[9]);
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_done: got %0d want 0", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run(32'h0000_0003, 32'h0000_0005, 2 * LAT_SMALL + 4, LAT_SMALL + 1, -1, -1);
        checks++;
        if (done_cnt !== 2 || out_log[2 * LAT_SMALL + 1][8] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_two_done: got cnt %0d want 2 with done at %0d",
                     done_cnt, 2 * LAT_SMALL + 1);
        end
        checks++;
        if (prod !== 64'd15) begin
            errors++;
            $display("FAIL b2b_product: got %h want f", prod);
        end
        run(32'h0000_0003, 32'h0000_0005, 2 * LAT_SMALL + 4, LAT_SMALL, -1, -1);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL b2b_start_in_done: got %0d want 1", done_cnt);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.a     = '0;
        prod      = '0;
        test_reset();
        test_byte_ff();
        test_all_ones();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
